// File: rtl/conv1_bm_sram_ctrl_pkg.sv
// Shared types and constants for the conv1 SRAM controller.
//   state_t : controller FSM states
//   grant_t : per-cycle SRAM slot owner
//   READ_LAT: cycles from read grant (pins registered) to rd_data_valid
package conv1_sram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    DRAIN
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_WR,
    GNT_RD
  } grant_t;

  localparam int unsigned READ_LAT = 2;

endpackage

// File: rtl/conv1_bm_sram_ctrl_rr_arb2.sv
// sram_rr_arb2: two-requester round-robin arbiter for the single SRAM port.
// Ports:
//   clk0, rst_n : clock, synchronous active-low reset
//   wr_req      : write requester wants the slot
//   rd_req      : burst engine wants the slot
//   grant       : combinational owner of this cycle's slot
// last_grant only moves on contended cycles, so sustained writes against a
// burst alternate 1:1; after reset the write side wins the first contest.
module sram_rr_arb2
  import conv1_sram_ctrl_pkg::*;
(
  input  logic   clk0,
  input  logic   rst_n,
  input  logic   wr_req,
  input  logic   rd_req,
  output grant_t grant
);

  grant_t last_grant;

  always_comb begin
    grant = GNT_NONE;
    if (wr_req && rd_req) begin
      grant = (last_grant == GNT_RD) ? GNT_WR : GNT_RD;
    end else if (wr_req) begin
      grant = GNT_WR;
    end else if (rd_req) begin
      grant = GNT_RD;
    end
  end

  always_ff @(posedge clk0) begin
    if (!rst_n) begin
      last_grant <= GNT_RD;
    end else if (wr_req && rd_req) begin
      last_grant <= grant;
    end
  end

endmodule

// File: rtl/conv1_bm_sram_ctrl.sv
// conv1_bm_sram_ctrl: shares one single-port 16x16 OpenRAM macro between a
// word-write loader and a burst-read engine.
// Ports:
//   clk0, rst_n                  : clock (also the macro clock), sync active-low reset
//   wr_valid/wr_ready            : write handshake, wr_addr/wr_data payload
//   rd_req_valid/rd_req_ready    : burst request, rd_base/rd_len payload (len 0..DEPTH)
//   rd_data_valid/rd_data/rd_last: returned beats, no backpressure
//   busy                         : burst active or read still in flight
//   sram_csb0/web0/addr0/din0    : registered macro pins (csb/web active-low)
//   sram_dout0                   : macro read data
module conv1_bm_sram_ctrl
  import conv1_sram_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk0,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_req_valid,
  output logic                  rd_req_ready,
  input  logic [ADDR_WIDTH-1:0] rd_base,
  input  logic [ADDR_WIDTH:0]   rd_len,
  output logic                  rd_data_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  busy,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0
);

  localparam logic [ADDR_WIDTH:0] BEAT_ONE = (ADDR_WIDTH+1)'(1);

  state_t                state, state_n;
  grant_t                grant;
  logic                  arb_wr_req, arb_rd_req;
  logic                  issue_wr, issue_rd, issue_last, rd_hs;
  logic [ADDR_WIDTH-1:0] addr_cnt;
  logic [ADDR_WIDTH:0]   beats_left;
  logic [READ_LAT-1:0]   pipe_v, pipe_l;

  sram_rr_arb2 u_arb (
    .clk0   (clk0),
    .rst_n  (rst_n),
    .wr_req (arb_wr_req),
    .rd_req (arb_rd_req),
    .grant  (grant)
  );

  assign issue_wr   = (grant == GNT_WR);
  assign issue_rd   = (grant == GNT_RD);
  assign issue_last = issue_rd && (beats_left == BEAT_ONE);
  assign busy       = (state != IDLE) || (|pipe_v);

  always_comb begin
    state_n      = state;
    wr_ready     = 1'b0;
    rd_req_ready = 1'b0;
    rd_hs        = 1'b0;
    arb_wr_req   = rst_n && wr_valid;
    arb_rd_req   = rst_n && (state == BURST);
    if (rst_n) begin
      case (state)
        IDLE: begin
          wr_ready     = 1'b1;
          rd_req_ready = 1'b1;
          rd_hs        = rd_req_valid;
          if (rd_req_valid && (rd_len != '0)) state_n = BURST;
        end
        BURST: begin
          wr_ready = issue_wr;
          if (issue_last) state_n = DRAIN;
        end
        DRAIN: begin
          wr_ready = 1'b1;
          // The oldest stage is captured on this edge; leave once nothing
          // younger is still travelling.
          if (~|pipe_v[READ_LAT-2:0]) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk0) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk0) begin
    if (!rst_n) begin
      addr_cnt   <= '0;
      beats_left <= '0;
    end else if (rd_hs) begin
      addr_cnt   <= rd_base;
      beats_left <= rd_len;
    end else if (issue_rd) begin
      addr_cnt   <= addr_cnt + ADDR_WIDTH'(1);
      beats_left <= beats_left - BEAT_ONE;
    end
  end

  always_ff @(posedge clk0) begin
    if (!rst_n) begin
      sram_csb0  <= 1'b1;
      sram_web0  <= 1'b1;
      sram_addr0 <= '0;
      sram_din0  <= '0;
    end else if (issue_wr) begin
      sram_csb0  <= 1'b0;
      sram_web0  <= 1'b0;
      sram_addr0 <= wr_addr;
      sram_din0  <= wr_data;
    end else if (issue_rd) begin
      sram_csb0  <= 1'b0;
      sram_web0  <= 1'b1;
      sram_addr0 <= addr_cnt;
    end else begin
      sram_csb0  <= 1'b1;
      sram_web0  <= 1'b1;
    end
  end

  // pipe_v[0] rises with the read pins, pipe_v[1] when the macro captures
  // them; the data is on sram_dout0 at the following edge.
  always_ff @(posedge clk0) begin
    if (!rst_n) begin
      pipe_v        <= '0;
      pipe_l        <= '0;
      rd_data_valid <= 1'b0;
      rd_last       <= 1'b0;
      rd_data       <= '0;
    end else begin
      pipe_v        <= {pipe_v[READ_LAT-2:0], issue_rd};
      pipe_l        <= {pipe_l[READ_LAT-2:0], issue_last};
      rd_data_valid <= pipe_v[READ_LAT-1];
      rd_last       <= pipe_v[READ_LAT-1] && pipe_l[READ_LAT-1];
      if (pipe_v[READ_LAT-1]) rd_data <= sram_dout0;
    end
  end

endmodule

// File: tb/tb_conv1_bm_sram_ctrl.sv
// Bench for conv1_bm_sram_ctrl: behavioural macro model, per-cycle reference
// of slot ownership, and a scoreboard of expected read beats with arrival cycle.
module tb_conv1_bm_sram_ctrl;

  logic        clk0;
  logic        rst_n;
  logic        wr_valid, wr_ready;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        rd_req_valid, rd_req_ready;
  logic [3:0]  rd_base;
  logic [4:0]  rd_len;
  logic        rd_data_valid, rd_last, busy;
  logic [15:0] rd_data;
  logic        sram_csb0, sram_web0;
  logic [3:0]  sram_addr0;
  logic [15:0] sram_din0, sram_dout0;

  conv1_bm_sram_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) dut (
    .clk0(clk0), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
    .rd_base(rd_base), .rd_len(rd_len),
    .rd_data_valid(rd_data_valid), .rd_data(rd_data), .rd_last(rd_last), .busy(busy),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_addr0(sram_addr0),
    .sram_din0(sram_din0), .sram_dout0(sram_dout0)
  );

  initial clk0 = 1'b0;
  always #5 clk0 = ~clk0;

  int unsigned cyc = 0;
  always @(posedge clk0) cyc <= cyc + 1;

  // Macro model: pins registered at posedge, array accessed at negedge.
  logic [15:0] ram [16];
  logic        m_csb, m_web;
  logic [3:0]  m_addr_p;
  logic [15:0] m_din;
  always @(posedge clk0) begin
    m_csb    <= sram_csb0;
    m_web    <= sram_web0;
    m_addr_p <= sram_addr0;
    m_din    <= sram_din0;
  end
  always @(negedge clk0) begin
    if (m_csb === 1'b0) begin
      if (!m_web) ram[m_addr_p] <= m_din;
      else        sram_dout0    <= ram[m_addr_p];
    end
  end

  typedef struct {
    logic [15:0] d;
    logic        l;
    int unsigned t;
  } beat_t;
  beat_t q[$];

  int unsigned n_checks = 0, n_err = 0;
  int unsigned m_reads = 0, obs_reads = 0;
  bit          chk_en = 0;

  // Reference state
  logic [15:0] mmem [16];
  int unsigned m_beats = 0, m_drain = 0;
  logic [3:0]  m_addr = '0;
  bit          m_last_rd = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock of stimulus plus the reference's view of who owns that slot.
  task automatic step(input bit wv, input logic [3:0] wa, input logic [15:0] wd,
                      input bit rv, input logic [3:0] rb, input logic [4:0] rl,
                      input bit rstv);
    int unsigned n;
    bit exp_wr, exp_rq, in_idle;
    beat_t b;
    @(negedge clk0); #1;
    wr_valid = wv; wr_addr = wa; wr_data = wd;
    rd_req_valid = rv; rd_base = rb; rd_len = rl; rst_n = rstv;
    #1;
    n       = cyc + 1;
    in_idle = (m_beats == 0) && (m_drain == 0);
    exp_wr  = 0;
    exp_rq  = 0;
    if (chk_en) chk("busy", {31'b0, busy}, {31'b0, !in_idle});
    if (!rstv) begin
      m_beats = 0; m_drain = 0; m_last_rd = 1;
      while (q.size() > 0 && q[$].t >= n) void'(q.pop_back());
    end else if (m_beats > 0) begin
      if (wv && m_last_rd) begin
        exp_wr = 1; mmem[wa] = wd; m_last_rd = 0;
      end else begin
        b.d = mmem[m_addr]; b.l = (m_beats == 1); b.t = n + 2;
        q.push_back(b);
        m_addr = m_addr + 4'd1; m_beats--; m_reads++;
        if (wv) m_last_rd = 1;
        if (m_beats == 0) m_drain = 2;
      end
    end else begin
      exp_wr = 1;
      if (wv) mmem[wa] = wd;
      if (m_drain > 0) m_drain--;
      else begin
        exp_rq = 1;
        if (rv && rl != 0) begin m_beats = rl; m_addr = rb; end
      end
    end
    if (chk_en) begin
      chk("wr_ready", {31'b0, wr_ready}, {31'b0, exp_wr});
      chk("rd_req_ready", {31'b0, rd_req_ready}, {31'b0, exp_rq});
    end
  endtask

  task automatic idle(input int unsigned k);
    for (int unsigned i = 0; i < k; i++) step(0, '0, '0, 0, '0, '0, 1);
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    step(1, a, d, 0, '0, '0, 1);
  endtask

  task automatic burst(input logic [3:0] b, input logic [4:0] l);
    step(0, '0, '0, 1, b, l, 1);
  endtask

  // Monitor: pops the scoreboard whenever a beat is presented.
  initial begin
    beat_t b;
    forever begin
      @(negedge clk0);
      if (chk_en) begin
        if (!sram_csb0 && sram_web0) obs_reads++;
        while (q.size() > 0 && q[0].t < cyc) begin
          n_checks++; n_err++;
          $display("FAIL missing_beat: actual none expected %h at cycle %0d", q[0].d, q[0].t);
          void'(q.pop_front());
        end
        if (rd_data_valid) begin
          if (q.size() == 0) begin
            n_checks++; n_err++;
            $display("FAIL unexpected_beat: actual %h expected no beat (cycle %0d)", rd_data, cyc);
          end else begin
            b = q.pop_front();
            chk("rd_data", {16'b0, rd_data}, {16'b0, b.d});
            chk("rd_last", {31'b0, rd_last}, {31'b0, b.l});
            chk("rd_arrival_cycle", cyc, b.t);
          end
        end
      end
    end
  end

  initial begin
    wr_valid = 0; wr_addr = '0; wr_data = '0;
    rd_req_valid = 0; rd_base = '0; rd_len = '0; rst_n = 0;
    for (int i = 0; i < 16; i++) mmem[i] = '0;

    step(0, '0, '0, 0, '0, '0, 0);
    step(0, '0, '0, 0, '0, '0, 0);
    @(posedge clk0); #1;
    chk_en = 1;
    chk("reset_csb0", {31'b0, sram_csb0}, 32'd1);
    chk("reset_web0", {31'b0, sram_web0}, 32'd1);
    chk("reset_addr0", {28'b0, sram_addr0}, 32'd0);
    chk("reset_din0", {16'b0, sram_din0}, 32'd0);
    chk("reset_rd_data", {16'b0, rd_data}, 32'd0);
    chk("reset_rd_valid", {31'b0, rd_data_valid}, 32'd0);
    chk("reset_rd_last", {31'b0, rd_last}, 32'd0);

    // Single write then one-beat burst of the same word.
    wr(4'd3, 16'hA5A5);
    burst(4'd3, 5'd1);
    idle(5);

    // Fill, then wrapping burst 14,15,0,1.
    for (int unsigned a = 0; a < 16; a++) wr(4'(a), 16'(a * 16'h0101));
    burst(4'd14, 5'd4);
    idle(6);

    // Full burst against sustained writes.
    burst(4'd0, 5'd16);
    for (int unsigned i = 0; i < 36; i++) wr(4'($urandom_range(0, 15)), 16'($urandom));
    idle(4);

    // Zero-length burst.
    burst(4'd7, 5'd0);
    idle(4);

    // Reset after three beats of a length-8 burst.
    burst(4'd2, 5'd8);
    idle(3);
    step(0, '0, '0, 0, '0, '0, 0);
    @(posedge clk0); #1;
    chk("midreset_csb0", {31'b0, sram_csb0}, 32'd1);
    chk("midreset_rd_valid", {31'b0, rd_data_valid}, 32'd0);
    idle(6);

    // Write granted one slot ahead of a read of the same address.
    burst(4'd5, 5'd2);
    wr(4'd5, 16'h1234);
    idle(6);

    // Random mix.
    for (int unsigned i = 0; i < 400; i++) begin
      step(bit'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom),
           ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)),
           5'($urandom_range(0, 16)), 1);
    end
    idle(8);

    chk("scoreboard_empty", q.size(), 32'd0);
    chk("read_slot_count", obs_reads, m_reads);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
